biquad8_coeff_loader: RTL and testbench
=======================================

BIQUAD8_COEFF_LOADER -- requirements
Module: biquad8_coeff_loader

Interface
REQ-001 SHALL have parameter NENTRIES, default 32: coefficient table depth, power of two, maximum 32.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum wb_clk_i cycles to wait for an ack per transaction.
REQ-003 SHALL have port wb_clk_i  in  1  sole clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port tbl_we_i  in  1  table write strobe.
REQ-006 SHALL have port tbl_adr_i  in  5  table entry index.
REQ-007 SHALL have port tbl_dat_i  in  23  entry {word[4:0], coeff[17:0]}; word is the target register word address (byte address = {word,2'b00}).
REQ-008 SHALL have port cnt_i  in  6  number of entries to send, 0..NENTRIES; sampled at start.
REQ-009 SHALL have port start_i  in  1  begin load sequence.
REQ-010 SHALL have port busy_o  out  1  sequence in progress.
REQ-011 SHALL have port done_o  out  1  one-cycle pulse on successful completion.
REQ-012 SHALL have port err_o  out  1  sticky failure flag (timeout or wb_err_i).
REQ-013 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  WISHBONE initiator controls.
REQ-014 SHALL have port wb_adr_o  out  7  byte address.
REQ-015 SHALL have port wb_dat_o  out  32  write data.
REQ-016 SHALL have port wb_sel_o  out  4  byte selects.
REQ-017 SHALL have ports wb_ack_i, wb_err_i, wb_rty_i  in  1 each  target responses; wb_rty_i is treated as wb_err_i.

Function
REQ-018 SHALL implement the states IDLE, WR (coefficient write active), GAP (one idle cycle), UPD (update write active) and FAIL.
REQ-019 SHALL, in IDLE, write tbl_dat_i into entry tbl_adr_i when tbl_we_i=1; tbl_we_i SHALL be ignored in every other state.
REQ-020 SHALL, on start_i=1 in IDLE or FAIL, latch cnt_i, clear err_o, zero the entry index, and enter WR (cnt>0) or UPD (cnt=0) on the next edge; cyc/stb SHALL be high in the cycle after start_i.
REQ-021 SHALL ignore start_i while busy_o=1.
REQ-022 SHALL drive, in WR: cyc=stb=we=1, adr={word,2'b00}, dat={14'b0,coeff}, sel=4'hF.
REQ-023 SHALL hold adr/dat/sel stable for every cycle stb is high, because the target captures data on every strobed write cycle.
REQ-024 SHALL, on wb_ack_i in WR, drop cyc/stb on the next edge, increment the index, and enter GAP; GAP SHALL last exactly one cycle with cyc=stb=0.
REQ-025 SHALL, on leaving GAP, enter WR if index<cnt and UPD otherwise.
REQ-026 SHALL drive, in UPD: adr=7'h00, dat=32'h0000_0001, sel=4'b0001 (global update only; bits 16/23/31 zero).
REQ-027 SHALL, on wb_ack_i in UPD, enter IDLE and pulse done_o for one cycle.
REQ-028 SHALL keep an ack-wait counter that is cleared on each stb assertion; if it reaches TIMEOUT without ack, or wb_err_i/wb_rty_i=1 in WR or UPD, the block SHALL drop cyc/stb, set err_o and enter FAIL with no update write issued.
REQ-029 SHALL ignore wb_ack_i outside WR and UPD.
REQ-030 SHALL assert busy_o in WR, GAP and UPD only.
REQ-031 SHALL use the table only in the ack-wait timing path; the target ack latency is multi-cycle, so no throughput requirement applies.

Reset
REQ-032 SHALL, when wb_rst_i=1 (including mid-transaction), on the next edge set state IDLE; cyc, stb, we, busy_o, done_o and err_o to 0; index, latched count and ack-wait counter to 0; adr, dat and sel to 0.
REQ-033 SHALL NOT reset table contents.

Structure
REQ-034 SHALL place in shared package biquad8_pkg: register byte addresses (UPDATE=7'h00, FIR=7'h04, IIR=7'h08, INC=7'h0C, POLEFIR base=7'h10/mask=7'h70), the update data constant, and the loader state enum.
REQ-035 SHALL contain one sub-module, biquad8_coeff_table: NENTRIES x 23 distributed RAM with one synchronous write port and one asynchronous read port.

Verification
REQ-036 SHALL verify: load 3 entries {1,0x00123},{2,0x3FFFF},{4,0x00001}, cnt=3, ack after 5 cycles -> writes to 0x04, 0x08, 0x10 with dat 0x00123/0x3FFFF/0x00001, stb low for 1 cycle between each, then adr 0x00 dat 0x1 sel 0x1, done_o pulse, err_o=0.
REQ-037 SHALL verify: cnt=0, start -> only the update write is issued, then done_o.
REQ-038 SHALL verify: ack withheld, TIMEOUT=16 -> cyc drops 16 cycles after stb rose, err_o=1, no write to 0x00; a new start clears err_o.
REQ-039 SHALL verify: wb_err_i on the 2nd write -> FAIL, err_o=1, third entry not sent.
REQ-040 SHALL verify: wb_rst_i during WAIT of the 2nd write -> next cycle cyc=0, busy_o=0; a later start with cnt=1 completes normally.
REQ-041 SHALL verify: start_i and tbl_we_i pulsed while busy -> no restart, table unchanged.

Source files
------------

// File: rtl/biquad8_pkg.sv
// rtl/biquad8_pkg.sv - shared register map, update constant and loader state type
package biquad8_pkg;

  localparam logic [6:0]  ADR_UPDATE       = 7'h00;
  localparam logic [6:0]  ADR_FIR          = 7'h04;
  localparam logic [6:0]  ADR_IIR          = 7'h08;
  localparam logic [6:0]  ADR_INC          = 7'h0C;
  localparam logic [6:0]  ADR_POLEFIR_BASE = 7'h10;
  localparam logic [6:0]  ADR_POLEFIR_MASK = 7'h70;

  // Global update only: per-bank update bits 16/23/31 stay clear.
  localparam logic [31:0] UPDATE_DATA = 32'h0000_0001;
  localparam logic [3:0]  UPDATE_SEL  = 4'b0001;

  localparam int ENTRY_W = 23;
  localparam int COEFF_W = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_GAP,
    ST_UPD,
    ST_FAIL
  } loader_state_e;

  function automatic logic [6:0] word_to_adr(input logic [4:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/biquad8_coeff_table.sv
// rtl/biquad8_coeff_table.sv - coefficient table, synchronous write, asynchronous read
module biquad8_coeff_table
  import biquad8_pkg::*;
#(
  parameter int NENTRIES = 32,
  parameter int AW       = 5
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_wadr,
  input  logic [ENTRY_W-1:0] i_wdat,
  input  logic [AW-1:0]      i_radr,
  output logic [ENTRY_W-1:0] o_rdat
);

  logic [ENTRY_W-1:0] r_mem [NENTRIES];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wadr] <= i_wdat;
    end
  end

  assign o_rdat = r_mem[i_radr];

endmodule

// File: rtl/biquad8_coeff_loader.sv
// rtl/biquad8_coeff_loader.sv - WISHBONE initiator that streams table coefficients then a global update
module biquad8_coeff_loader
  import biquad8_pkg::*;
#(
  parameter int NENTRIES = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        tbl_we_i,
  input  logic [4:0]  tbl_adr_i,
  input  logic [22:0] tbl_dat_i,
  input  logic [5:0]  cnt_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [6:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int AW = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  loader_state_e r_state;
  loader_state_e w_next;
  logic [5:0]    r_idx;
  logic [5:0]    r_cnt;
  logic [TW-1:0] r_wait;
  logic          r_err;
  logic          r_done;

  logic               w_start;
  logic               w_fault;
  logic               w_expired;
  logic               w_tbl_we;
  logic [ENTRY_W-1:0] w_entry;

  assign w_start   = start_i && (r_state == ST_IDLE || r_state == ST_FAIL);
  assign w_fault   = wb_err_i || wb_rty_i;
  assign w_expired = (r_wait == WAIT_LAST) && !wb_ack_i;
  assign w_tbl_we  = tbl_we_i && (r_state == ST_IDLE);

  biquad8_coeff_table #(
    .NENTRIES(NENTRIES),
    .AW      (AW)
  ) u_table (
    .i_clk (wb_clk_i),
    .i_we  (w_tbl_we),
    .i_wadr(tbl_adr_i[AW-1:0]),
    .i_wdat(tbl_dat_i),
    .i_radr(r_idx[AW-1:0]),
    .o_rdat(w_entry)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_UPD) && (w_next == ST_IDLE);
      if (w_start) begin
        r_cnt <= cnt_i;
        r_idx <= '0;
        r_err <= 1'b0;
      end else if (r_state == ST_WR && w_next == ST_GAP) begin
        r_idx <= r_idx + 6'd1;
      end
      if ((r_state == ST_WR || r_state == ST_UPD) && w_next == ST_FAIL) begin
        r_err <= 1'b1;
      end
      // Any change of state restarts the count, so each new strobe begins at zero.
      if ((r_state == ST_WR || r_state == ST_UPD) && w_next == r_state) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_FAIL: begin
        if (start_i) begin
          w_next = (cnt_i == '0) ? ST_UPD : ST_WR;
        end
      end
      ST_WR: begin
        if (w_fault || w_expired) begin
          w_next = ST_FAIL;
        end else if (wb_ack_i) begin
          w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        w_next = (r_idx < r_cnt) ? ST_WR : ST_UPD;
      end
      ST_UPD: begin
        if (w_fault || w_expired) begin
          w_next = ST_FAIL;
        end else if (wb_ack_i) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_sel_o = '0;
    busy_o   = 1'b0;
    case (r_state)
      ST_WR: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = word_to_adr(w_entry[ENTRY_W-1:COEFF_W]);
        wb_dat_o = {14'd0, w_entry[COEFF_W-1:0]};
        wb_sel_o = 4'hF;
        busy_o   = 1'b1;
      end
      ST_GAP: begin
        busy_o = 1'b1;
      end
      ST_UPD: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = ADR_UPDATE;
        wb_dat_o = UPDATE_DATA;
        wb_sel_o = UPDATE_SEL;
        busy_o   = 1'b1;
      end
      default: ;
    endcase
  end

  assign done_o = r_done;
  assign err_o  = r_err;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// tb/tb_biquad8_coeff_loader.sv - randomized self-checking bench with a transaction-level write model
module tb_biquad8_coeff_loader;

  logic        clk;
  logic        rst;
  logic        tbl_we;
  logic [4:0]  tbl_adr;
  logic [22:0] tbl_dat;
  logic [5:0]  cnt;
  logic        start;
  logic        busy, done, err;
  logic        cyc, stb, we;
  logic [6:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        ack, werr, rty;

  biquad8_coeff_loader #(.NENTRIES(32), .TIMEOUT(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .tbl_we_i (tbl_we),
    .tbl_adr_i(tbl_adr),
    .tbl_dat_i(tbl_dat),
    .cnt_i    (cnt),
    .start_i  (start),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .wb_cyc_o (cyc),
    .wb_stb_o (stb),
    .wb_we_o  (we),
    .wb_adr_o (adr),
    .wb_dat_o (dat),
    .wb_sel_o (sel),
    .wb_ack_i (ack),
    .wb_err_i (werr),
    .wb_rty_i (rty)
  );

  typedef struct {
    logic [6:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          upd;
  } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [22:0] m_tbl [32];
  bit          m_fail = 0;
  wr_t         exp_q[$];
  logic [6:0]  seen_adr[$];
  logic [31:0] seen_dat[$];

  int rsp_lat = 1, rsp_mode = 0, rsp_k = 0, wr_num = 0, rsp_hi = 0;
  int done_cnt = 0, last_run = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Target model: acks (or faults) in the rsp_lat-th strobed cycle of each transfer.
  initial begin
    ack = 0; werr = 0; rty = 0;
    forever begin
      @(posedge clk);
      #1;
      ack = 0; werr = 0; rty = 0;
      if (stb) begin
        if (rsp_hi == 0) wr_num++;
        rsp_hi++;
        if (rsp_mode != 0 && wr_num == rsp_k) begin
          if (rsp_mode == 1) werr = (rsp_hi == rsp_lat);
          if (rsp_mode == 2) rty  = (rsp_hi == rsp_lat);
        end else begin
          ack = (rsp_hi == rsp_lat);
        end
      end else begin
        rsp_hi = 0;
      end
    end
  end

  initial begin
    bit done_exp = 0, gap_chk = 0, prev_stb = 0;
    int hi_run = 0, low_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_exp = 0; gap_chk = 0; prev_stb = 0; hi_run = 0; low_run = 0;
      end else begin
        check("done_pulse", done, done_exp);
        if (done) done_cnt++;
        done_exp = 0;
        check("cyc_eq_stb", cyc, stb);
        check("we_eq_stb", we, stb);
        if (stb) begin
          if (!prev_stb) begin
            if (gap_chk) check("gap_len", low_run, 1);
            gap_chk = 0;
            hi_run = 0;
            seen_adr.push_back(adr);
            seen_dat.push_back(dat);
          end
          hi_run++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_strobe: adr 0x%0h dat 0x%0h, no write expected", adr, dat);
          end else begin
            check("wb_adr", adr, exp_q[0].adr);
            check("wb_dat", dat, exp_q[0].dat);
            check("wb_sel", sel, exp_q[0].sel);
            check("busy_in_write", busy, 1);
            if (ack) begin
              if (exp_q[0].upd) done_exp = 1;
              else gap_chk = 1;
              exp_q.delete(0);
            end
          end
        end else begin
          if (prev_stb) begin
            last_run = hi_run;
            low_run = 0;
          end
          low_run++;
          if (gap_chk) check("gap_busy", busy, 1);
        end
        prev_stb = stb;
      end
    end
  end

  task automatic build_q(input int n, input int keep);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{adr: 7'(m_tbl[i][22:18] * 4), dat: 32'(m_tbl[i][17:0]), sel: 4'hF, upd: 0});
    end
    exp_q.push_back('{adr: 7'h00, dat: 32'h1, sel: 4'h1, upd: 1});
    while (exp_q.size() > keep) exp_q.delete(exp_q.size() - 1);
  endtask

  task automatic write_entry(input int a, input logic [22:0] d);
    @(negedge clk);
    tbl_we = 1; tbl_adr = 5'(a); tbl_dat = d;
    @(negedge clk);
    tbl_we = 0;
    if (!m_fail) m_tbl[a] = d;
  endtask

  task automatic run_seq(input int n, input int lat, input int mode, input int k,
                         input bit interfere, output int cycles);
    int d0;
    bit fail;
    fail = (mode != 0);
    build_q(n, fail ? k : n + 1);
    seen_adr.delete();
    seen_dat.delete();
    rsp_lat = lat; rsp_mode = mode; rsp_k = k; wr_num = 0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1; cnt = 6'(n);
    @(negedge clk);
    start = 0;
    check("stb_after_start", stb, 1);
    check("err_cleared_by_start", err, 0);
    cycles = 0;
    while (busy && cycles < 3000) begin
      if (interfere && cycles == 3) begin
        start = 1; cnt = 6'd7; tbl_we = 1; tbl_adr = 5'd0; tbl_dat = ~m_tbl[0];
      end
      if (interfere && cycles == 4) begin
        start = 0; tbl_we = 0;
      end
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL seq_timeout: busy still %0d after %0d cycles, expected to drop", busy, cycles);
    end
    @(negedge clk);
    check("err_flag", err, fail);
    check("writes_outstanding", exp_q.size(), fail ? 1 : 0);
    check("done_count", done_cnt - d0, fail ? 0 : 1);
    if (mode == 3) check("timeout_stb_cycles", last_run, 16);
    if (fail) check("fault_at_write", wr_num, k);
    m_fail = fail;
    exp_q.delete();
  endtask

  initial begin
    int cyc_n, n, lat, r, mode, k, wait_n;
    rst = 1; tbl_we = 0; tbl_adr = 0; tbl_dat = 0; cnt = 0; start = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_adr", adr, 0);
    check("rst_dat", dat, 0);
    check("rst_sel", sel, 0);
    rst = 0;

    for (int i = 0; i < 32; i++) write_entry(i, 23'($urandom));

    write_entry(0, {5'd1, 18'h00123});
    write_entry(1, {5'd2, 18'h3FFFF});
    write_entry(2, {5'd4, 18'h00001});
    run_seq(3, 5, 0, 0, 0, cyc_n);
    check("three_entry_busy_cycles", cyc_n, 23);
    check("three_entry_writes", seen_adr.size(), 4);
    if (seen_adr.size() == 4) begin
      check("lit_adr0", seen_adr[0], 7'h04);
      check("lit_adr1", seen_adr[1], 7'h08);
      check("lit_adr2", seen_adr[2], 7'h10);
      check("lit_adr3", seen_adr[3], 7'h00);
      check("lit_dat0", seen_dat[0], 32'h00123);
      check("lit_dat1", seen_dat[1], 32'h3FFFF);
      check("lit_dat2", seen_dat[2], 32'h00001);
      check("lit_dat3", seen_dat[3], 32'h1);
    end

    run_seq(0, 5, 0, 0, 0, cyc_n);
    check("cnt0_busy_cycles", cyc_n, 5);
    check("cnt0_writes", seen_adr.size(), 1);

    run_seq(2, 5, 3, 1, 0, cyc_n);
    check("timeout_busy_cycles", cyc_n, 16);
    write_entry(0, ~m_tbl[0]);
    run_seq(1, 16, 0, 0, 0, cyc_n);

    run_seq(3, 4, 1, 2, 0, cyc_n);
    check("err2_writes_seen", seen_adr.size(), 2);
    run_seq(2, 3, 2, 3, 0, cyc_n);

    build_q(3, 4);
    rsp_lat = 10; rsp_mode = 0; rsp_k = 0; wr_num = 0;
    @(negedge clk);
    start = 1; cnt = 6'd3;
    @(negedge clk);
    start = 0;
    wait_n = 0;
    while (!(wr_num == 2 && rsp_hi >= 3) && wait_n < 500) begin
      wait_n++;
      @(negedge clk);
    end
    check("reach_second_write", wait_n < 500, 1);
    rst = 1;
    @(posedge clk);
    #1;
    check("midrst_cyc", cyc, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_adr", adr, 0);
    exp_q.delete();
    m_fail = 0;
    @(negedge clk);
    rst = 0;
    run_seq(1, 4, 0, 0, 0, cyc_n);

    run_seq(2, 6, 0, 0, 1, cyc_n);
    run_seq(1, 3, 0, 0, 0, cyc_n);

    for (int it = 0; it < 30; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 4)); w++) begin
        write_entry(int'($urandom_range(0, 31)), 23'($urandom));
      end
      n = (it == 7) ? 32 : int'($urandom_range(0, 8));
      lat = int'($urandom_range(1, 16));
      r = int'($urandom_range(0, 9));
      mode = (r <= 6) ? 0 : r - 6;
      k = (mode != 0) ? int'($urandom_range(1, n + 1)) : 0;
      run_seq(n, lat, mode, k, 0, cyc_n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
